cache_fill_fsm: RTL
===================

// Module: cache_fill_fsm
// PURPOSE
//  Miss-handling controller between the pipeline's I- or D-cache lookup and multi-cycle main memory.
//  On a cache miss it stalls the pipeline and fetches the aligned block one word at a time.
//  Each returned word is written into the data array, then the tag/valid entry is written.
//  Signals completion so the stalled IF or MEM stage re-probes and hits.
//  One instance per cache; the I-cache and D-cache instances arbitrate for memory externally.
// PARAMETERS
//  ADDR_W       16  address / data word width
//  BLOCK_WORDS  8   16-bit words per cache block (power of 2, >=2)
// PORTS
//  clk                in   1       single clock, rising edge
//  rst_n              in   1       asynchronous reset, active-low
//  miss_detected      in   1       lookup missed; held high by requester until fill_done
//  miss_address       in   ADDR_W  byte address of the missing access
//  fsm_busy           out  1       fill in progress; pipeline stalls while high
//  memory_request     out  1       issue one memory read this cycle
//  memory_address     out  ADDR_W  byte address of the read being issued
//  memory_data_valid  in   1       memory returns one word this cycle (in request order)
//  memory_data        in   ADDR_W  returned word
//  write_data_array   out  1       write fill_data into data array word fill_word_sel
//  write_tag_array    out  1       write tag+valid for block base (same cycle as last word)
//  fill_word_sel      out  log2(BLOCK_WORDS)  word index within block
//  fill_data          out  ADDR_W  = memory_data (pass-through)
//  fill_done          out  1       one-cycle completion pulse
// BEHAVIOUR
//  Reset (async, immediate): state IDLE, counters 0, base 0; all outputs 0.
//  States: IDLE -> FILL -> DONE -> IDLE.
//  IDLE: fsm_busy = miss_detected (combinational, stalls in the miss cycle).
//    If miss_detected, latch base = miss_address with low log2(2*BLOCK_WORDS) bits cleared.
//    Also clear req_cnt/rsp_cnt and go to FILL.
//  FILL: fsm_busy=1.
//    memory_request=1 while req_cnt<BLOCK_WORDS; memory_address = base + 2*req_cnt; req_cnt++.
//    So requests issue on BLOCK_WORDS consecutive cycles beginning the cycle after the miss.
//  FILL, on memory_data_valid: write_data_array=1, fill_word_sel=rsp_cnt, rsp_cnt++.
//    When rsp_cnt==BLOCK_WORDS-1: also write_tag_array=1 and go to DONE.
//  FILL: gaps in memory_data_valid just wait; there is no timeout.
//  DONE (1 cycle): fsm_busy=1, fill_done=1. Always go to IDLE; miss_detected is ignored here.
//  memory_data_valid in IDLE/DONE is ignored: no array writes.
//  miss_address changes after the latch cycle are ignored.
//  Counters are log2(BLOCK_WORDS)+1 bits. Address math is mod 2^ADDR_W.
//    The aligned base never carries out of the block.
//  fill_word_sel/fill_data are don't-care when write_data_array=0; drive 0 in IDLE.
//  memory_address=0 when memory_request=0.
// STRUCTURE
//  Shared header cache_defs.vh holds BLOCK_WORDS, BLOCK_BYTES, offset width and state encodings.
//    IDLE=2'b00, FILL=2'b01, DONE=2'b10. It is reused by the cache data/tag array blocks.
//  Natural sub-module: fill_counter (clear, inc, count, terminal flag).
//    It is instantiated twice, for the request count and the response count.
//  State flops use the codebase's async-reset register cells.
// TESTING (bench memory model: fixed latency L, in-order, optional valid gaps)
//  1 Reset with rst_n=0 -> every output 0; after release, with miss_detected=0, fsm_busy stays 0.
//  2 Miss 0x1234 at T0, L=4:
//    - busy T0..T13; requests 0x1230,0x1232..0x123E at T1..T8.
//    - write_data_array T5..T12 with sel 0..7; write_tag_array at T12 only; fill_done at T13 only.
//  3 Miss 0xFFFF -> base 0xFFF0; last memory_address 0xFFFE, no wrap into 0x0000.
//  4 L=2 with valid dropped for 3 cycles after word 4 -> exactly 8 data writes with sel 0..7 in order.
//    Tag write coincides with the 8th; fill_done is 1 cycle later.
//  5 Assert rst_n=0 during the 3rd returned word -> outputs 0 immediately, with no tag write.
//    A fresh miss after release refetches from word 0.
//  6 miss_detected held through DONE plus spurious valid in IDLE -> no second fill, no array writes.
//    Busy drops the cycle after fill_done.

Source files
------------

// File: rtl/cache_fill_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module : cache_fill_fsm_pkg
// Purpose: Shared definitions for the cache miss fill controller and the
//          cache data/tag array blocks: default geometry, fill state
//          encodings and helpers that derive counter/offset widths.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package cache_fill_fsm_pkg;

  localparam int ADDR_W_DEFAULT      = 16;
  localparam int BLOCK_WORDS_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_DONE = 2'b10
  } fill_state_t;

  // Counters must reach BLOCK_WORDS itself, hence one extra bit.
  function automatic int cnt_width(input int block_words);
    return $clog2(block_words) + 1;
  endfunction

  // Byte-offset bits inside a block of 16-bit words.
  function automatic int offset_width(input int block_words);
    return $clog2(2 * block_words);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_fill_fsm_fill_counter.sv
`default_nettype none
// ============================================================================
// Module : cache_fill_fsm_fill_counter
// Purpose: Small up-counter with synchronous clear/increment and a flag that
//          is high while the count equals LIMIT.
// Ports  : clk, rst_n     clock, async active-low reset
//          clear, inc     clear has priority over increment
//          count          current count value
//          at_limit       count == LIMIT
// Rev    : 1.0  initial release
// ============================================================================
module cache_fill_fsm_fill_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == WIDTH'(LIMIT));

endmodule
`default_nettype wire

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module : cache_fill_fsm
// Purpose: Cache miss fill controller. On a miss it stalls the pipeline,
//          issues one memory read per cycle for every word of the aligned
//          block, writes each returned word into the data array, writes the
//          tag/valid entry with the last word and pulses fill_done.
// Ports  : clk, rst_n                 clock, async active-low reset
//          miss_detected/miss_address lookup miss request (held until done)
//          fsm_busy                    pipeline stall
//          memory_request/_address     one read issue per cycle
//          memory_data_valid/_data     in-order read returns
//          write_data_array, fill_word_sel, fill_data   data array write
//          write_tag_array             tag/valid write (with last word)
//          fill_done                   one-cycle completion pulse
// Rev    : 1.0  initial release
// ============================================================================
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           miss_detected,
  input  logic [ADDR_W-1:0]              miss_address,
  output logic                           fsm_busy,
  output logic                           memory_request,
  output logic [ADDR_W-1:0]              memory_address,
  input  logic                           memory_data_valid,
  input  logic [ADDR_W-1:0]              memory_data,
  output logic                           write_data_array,
  output logic                           write_tag_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_sel,
  output logic [ADDR_W-1:0]              fill_data,
  output logic                           fill_done
);

  localparam int CNT_W = cnt_width(BLOCK_WORDS);
  localparam int OFF_W = offset_width(BLOCK_WORDS);
  localparam int SEL_W = $clog2(BLOCK_WORDS);

  fill_state_t       state;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  req_cnt;
  logic [CNT_W-1:0]  rsp_cnt;
  logic              req_all_sent;
  logic              rsp_is_last;
  logic              cnt_clear;
  logic              in_idle;
  logic              in_fill;
  logic              unused_ok;

  assign in_idle   = (state == ST_IDLE);
  assign in_fill   = (state == ST_FILL);
  // Both counters sit at zero whenever a new miss can be accepted.
  assign cnt_clear = in_idle;

  cache_fill_fsm_fill_counter #(
    .WIDTH (CNT_W),
    .LIMIT (BLOCK_WORDS)
  ) u_req_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .inc      (memory_request),
    .count    (req_cnt),
    .at_limit (req_all_sent)
  );

  cache_fill_fsm_fill_counter #(
    .WIDTH (CNT_W),
    .LIMIT (BLOCK_WORDS - 1)
  ) u_rsp_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .inc      (write_data_array),
    .count    (rsp_cnt),
    .at_limit (rsp_is_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      base  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (miss_detected) begin
            base  <= {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (write_tag_array) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Requester may still hold miss_detected here; it is ignored.
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall already in the miss cycle. Reset must silence the stall even while
  // the requester keeps miss_detected asserted.
  assign fsm_busy = !in_idle || (miss_detected && rst_n);

  assign memory_request = in_fill && !req_all_sent;
  // Base is block aligned, so the word offset never carries out of the block.
  assign memory_address = memory_request
                        ? base + ADDR_W'({req_cnt, 1'b0})
                        : '0;

  assign write_data_array = in_fill && memory_data_valid;
  assign write_tag_array  = write_data_array && rsp_is_last;
  assign fill_word_sel    = write_data_array ? rsp_cnt[SEL_W-1:0] : '0;
  assign fill_data        = write_data_array ? memory_data : '0;
  assign fill_done        = (state == ST_DONE);

  // Offset bits of the miss address are dropped by alignment.
  assign unused_ok = &{1'b0, miss_address[OFF_W-1:0]};

endmodule
`default_nettype wire
